// File: rtl/bp_fetch_ctrl_pkg.sv
// Shared RV32I opcode encodings plus the branch-prediction metadata record
// that travels with each fetched instruction down to EX/MEM.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } opcode_t;

  // Perceptron output width carried in the metadata; the fetch controller's w_bits must match.
  localparam int y_bits = 8;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic              bp_br_en;
    logic [y_bits-1:0] y_out;
    logic [31:0]       bp_target;
  } bp_meta_t;

  function automatic logic [31:0] redirect_pc(input opcode_t op, input logic br_en,
                                              input logic [31:0] alu_out, input logic [31:0] pc);
    return ((op == op_jal) || ((op == op_br) && br_en)) ? alu_out : pc + 32'd4;
  endfunction

endpackage

// File: rtl/bp_fetch_ctrl_meta_stage.sv
// One pipeline shadow register for prediction metadata; 1-cycle latency.
// Holds while load=0; flush clears only the valid bit, the payload still loads.
module bp_meta_stage
  import rv32i_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     flush,
  input  bp_meta_t d,
  output bp_meta_t q
);

  bp_meta_t d_eff;

  always_comb begin
    d_eff       = d;
    d_eff.valid = d.valid & ~flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d_eff;
    end
  end

endmodule

// File: rtl/bp_fetch_ctrl.sv
// Fetch PC register, next-PC select and prediction-metadata pipe to EX/MEM.
// if_pc is registered (1 cycle); load=0 freezes everything, so a pending redirect waits.
module bp_fetch_ctrl
  import rv32i_types::*;
#(
  parameter int          w_bits   = y_bits,
  parameter logic [31:0] reset_pc = 32'h00000060,
  parameter int          cnt_bits = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  output logic [31:0]         if_pc,
  input  logic                if_bp_br_en,
  input  logic [w_bits-1:0]   if_y_out,
  input  logic [31:0]         if_bp_target,
  input  logic                bp_rst,
  input  opcode_t             exmem_opcode,
  input  logic                exmem_br_en,
  input  logic [31:0]         exmem_alu_out,
  output logic                exmem_valid,
  output logic [31:0]         exmem_pc,
  output logic                exmem_bp_br_en,
  output logic [w_bits-1:0]   exmem_y_out,
  output logic [31:0]         exmem_bp_target,
  output logic [cnt_bits-1:0] br_count,
  output logic [cnt_bits-1:0] mispred_count
);

  bp_meta_t            if_meta, ifid_q, idex_q, exmem_q;
  logic [31:0]         pc_q;
  logic                redirect;
  logic [cnt_bits-1:0] br_cnt_q, mis_cnt_q;

  // A redirect request from a squashed slot is stale and must not steer fetch.
  assign redirect = bp_rst & exmem_q.valid;

  always_comb begin
    if_meta           = '0;
    if_meta.valid     = 1'b1;
    if_meta.pc        = pc_q;
    if_meta.bp_br_en  = if_bp_br_en;
    if_meta.y_out     = if_y_out;
    if_meta.bp_target = if_bp_target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= reset_pc;
    end else if (load) begin
      pc_q <= redirect ? redirect_pc(exmem_opcode, exmem_br_en, exmem_alu_out, exmem_q.pc)
                       : if_bp_target;
    end
  end

  bp_meta_stage u_ifid  (.clk(clk), .rst(rst), .load(load), .flush(redirect), .d(if_meta), .q(ifid_q));
  bp_meta_stage u_idex  (.clk(clk), .rst(rst), .load(load), .flush(redirect), .d(ifid_q),  .q(idex_q));
  bp_meta_stage u_exmem (.clk(clk), .rst(rst), .load(load), .flush(redirect), .d(idex_q),  .q(exmem_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (load && exmem_q.valid) begin
      if ((exmem_opcode == op_br) && !(&br_cnt_q)) br_cnt_q <= br_cnt_q + cnt_bits'(1);
      if (bp_rst && !(&mis_cnt_q))                 mis_cnt_q <= mis_cnt_q + cnt_bits'(1);
    end
  end

  assign if_pc           = pc_q;
  assign exmem_valid     = exmem_q.valid;
  assign exmem_pc        = exmem_q.pc;
  assign exmem_bp_br_en  = exmem_q.bp_br_en;
  assign exmem_y_out     = exmem_q.y_out;
  assign exmem_bp_target = exmem_q.bp_target;
  assign br_count        = br_cnt_q;
  assign mispred_count   = mis_cnt_q;

endmodule

// File: tb/tb_bp_fetch_ctrl.sv
// Directed bench for bp_fetch_ctrl: a pipeline-level reference model compared every
// negative clock edge, plus hand-computed literal checks at key points.
module tb_bp_fetch_ctrl;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst, load, bp_rst, if_bp_br_en, exmem_br_en;
  logic [7:0]  if_y_out;
  logic [31:0] if_bp_target, exmem_alu_out, if_pc;
  opcode_t     exmem_opcode;
  logic        exmem_valid, exmem_bp_br_en;
  logic [31:0] exmem_pc, exmem_bp_target, br_count, mispred_count;
  logic [7:0]  exmem_y_out;

  bp_fetch_ctrl dut (
    .clk(clk), .rst(rst), .load(load), .if_pc(if_pc),
    .if_bp_br_en(if_bp_br_en), .if_y_out(if_y_out), .if_bp_target(if_bp_target),
    .bp_rst(bp_rst), .exmem_opcode(exmem_opcode), .exmem_br_en(exmem_br_en),
    .exmem_alu_out(exmem_alu_out), .exmem_valid(exmem_valid), .exmem_pc(exmem_pc),
    .exmem_bp_br_en(exmem_bp_br_en), .exmem_y_out(exmem_y_out),
    .exmem_bp_target(exmem_bp_target), .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic chk_en = 1'b0;

  // Model: fetch PC, a 3-deep pipe of in-flight fetch records, two counters.
  logic [31:0] m_pc, m_brc, m_mis;
  logic        pv[3];
  logic [31:0] ppc[3];
  logic        pbr[3];
  logic [7:0]  py[3];
  logic [31:0] ptg[3];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h60; m_brc = 0; m_mis = 0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 0; ppc[i] = 0; pbr[i] = 0; py[i] = 0; ptg[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic        taken_redirect;
    logic [31:0] tgt;
    if (!rst || !load) return;
    taken_redirect = bp_rst && pv[2];
    if (exmem_opcode == op_jal) tgt = exmem_alu_out;
    else if (exmem_opcode == op_br && exmem_br_en) tgt = exmem_alu_out;
    else tgt = ppc[2] + 32'd4;
    if (pv[2]) begin
      if (exmem_opcode == op_br && m_brc != 32'hFFFFFFFF) m_brc = m_brc + 1;
      if (bp_rst && m_mis != 32'hFFFFFFFF) m_mis = m_mis + 1;
    end
    for (int i = 2; i > 0; i--) begin
      pv[i] = pv[i-1]; ppc[i] = ppc[i-1]; pbr[i] = pbr[i-1]; py[i] = py[i-1]; ptg[i] = ptg[i-1];
    end
    pv[0] = 1'b1; ppc[0] = m_pc; pbr[0] = if_bp_br_en; py[0] = if_y_out; ptg[0] = if_bp_target;
    if (taken_redirect) begin
      for (int i = 0; i < 3; i++) pv[i] = 1'b0;
      m_pc = tgt;
    end else begin
      m_pc = if_bp_target;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("if_pc", if_pc, m_pc);
      cmp("exmem_valid", {31'd0, exmem_valid}, {31'd0, pv[2]});
      cmp("exmem_pc", exmem_pc, ppc[2]);
      cmp("exmem_bp_br_en", {31'd0, exmem_bp_br_en}, {31'd0, pbr[2]});
      cmp("exmem_y_out", {24'd0, exmem_y_out}, {24'd0, py[2]});
      cmp("exmem_bp_target", exmem_bp_target, ptg[2]);
      cmp("br_count", br_count, m_brc);
      cmp("mispred_count", mispred_count, m_mis);
    end
  end

  // Inputs change 1 time unit after the active edge; the model steps on the edge itself.
  task automatic cyc(input logic ld, input logic rq, input opcode_t op, input logic ben,
                     input logic [31:0] alu, input logic [31:0] tgt);
    load = ld; bp_rst = rq; exmem_opcode = op; exmem_br_en = ben; exmem_alu_out = alu;
    if_bp_target = tgt; if_bp_br_en = m_pc[2]; if_y_out = m_pc[9:2];
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, op_imm, 1'b0, 32'h0, m_pc + 32'd4);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; bp_rst = 1'b0; if_bp_br_en = 1'b0; if_y_out = '0;
    if_bp_target = '0; exmem_opcode = op_imm; exmem_br_en = 1'b0; exmem_alu_out = '0;
    #1 rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    cmp("lit_reset_pc", if_pc, 32'h60);

    run(1);
    cmp("lit_first_fetch", if_pc, 32'h64);
    run(2);
    cmp("lit_exmem_valid", {31'd0, exmem_valid}, 32'd1);
    cmp("lit_exmem_pc", exmem_pc, 32'h60);
    cmp("lit_exmem_y", {24'd0, exmem_y_out}, 32'h18);
    cmp("lit_exmem_tgt", exmem_bp_target, 32'h64);

    cyc(1'b1, 1'b1, op_br, 1'b1, 32'h200, m_pc + 32'd4);
    cmp("lit_taken_pc", if_pc, 32'h200);
    cmp("lit_taken_squash", {31'd0, exmem_valid}, 32'd0);
    cmp("lit_taken_brc", br_count, 32'd1);
    cmp("lit_taken_mis", mispred_count, 32'd1);

    cyc(1'b1, 1'b1, op_br, 1'b1, 32'h77770000, m_pc + 32'd4);
    cmp("lit_stale_rst_pc", if_pc, 32'h204);
    cmp("lit_stale_rst_mis", mispred_count, 32'd1);
    run(2);
    cmp("lit_refill_pc", exmem_pc, 32'h200);

    cyc(1'b1, 1'b1, op_jal, 1'b0, 32'h80, m_pc + 32'd4);
    cmp("lit_jal80_pc", if_pc, 32'h80);
    run(3);
    cyc(1'b1, 1'b1, op_br, 1'b0, 32'h999, m_pc + 32'd4);
    cmp("lit_nt_pc", if_pc, 32'h84);
    cmp("lit_nt_brc", br_count, 32'd2);
    run(3);
    cyc(1'b1, 1'b1, op_jal, 1'b0, 32'h400, m_pc + 32'd4);
    cmp("lit_jal400_pc", if_pc, 32'h400);
    cmp("lit_jal400_brc", br_count, 32'd2);
    cmp("lit_jal400_mis", mispred_count, 32'd4);
    run(3);
    cyc(1'b1, 1'b0, op_br, 1'b1, 32'h0, m_pc + 32'd4);
    cmp("lit_good_br_brc", br_count, 32'd3);
    cmp("lit_good_br_mis", mispred_count, 32'd4);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, op_jal, 1'b0, 32'h300, m_pc + 32'd4);
    cmp("lit_stall_pc", if_pc, 32'h410);
    cmp("lit_stall_mis", mispred_count, 32'd4);
    cyc(1'b1, 1'b1, op_jal, 1'b0, 32'h300, m_pc + 32'd4);
    cmp("lit_unstall_pc", if_pc, 32'h300);
    cmp("lit_unstall_mis", mispred_count, 32'd5);
    cyc(1'b1, 1'b1, op_jal, 1'b0, 32'h300, m_pc + 32'd4);
    cmp("lit_once_pc", if_pc, 32'h304);
    cmp("lit_once_mis", mispred_count, 32'd5);
    run(2);

    force dut.mis_cnt_q = 32'hFFFFFFFF;
    m_mis = 32'hFFFFFFFF;
    cyc(1'b1, 1'b1, op_jal, 1'b0, 32'h500, m_pc + 32'd4);
    release dut.mis_cnt_q;
    cmp("lit_sat_mis", mispred_count, 32'hFFFFFFFF);
    run(3);
    cyc(1'b1, 1'b1, op_jal, 1'b0, 32'h600, m_pc + 32'd4);
    cmp("lit_sat2_mis", mispred_count, 32'hFFFFFFFF);
    cmp("lit_jal600_pc", if_pc, 32'h600);

    cyc(1'b1, 1'b0, op_imm, 1'b0, 32'h0, 32'hFFFFFFFC);
    cmp("lit_top_pc", if_pc, 32'hFFFFFFFC);
    run(3);
    cyc(1'b1, 1'b1, op_br, 1'b0, 32'h123, m_pc + 32'd4);
    cmp("lit_wrap_pc", if_pc, 32'h0);

    rst = 1'b0;
    model_reset();
    #1;
    cmp("lit_arst_pc", if_pc, 32'h60);
    cmp("lit_arst_valid", {31'd0, exmem_valid}, 32'd0);
    cmp("lit_arst_brc", br_count, 32'd0);
    cmp("lit_arst_mis", mispred_count, 32'd0);
    cyc(1'b1, 1'b1, op_br, 1'b1, 32'h200, 32'h64);
    cmp("lit_arst_hold_pc", if_pc, 32'h60);
    rst = 1'b1;
    cyc(1'b1, 1'b0, op_imm, 1'b0, 32'h0, 32'h64);
    cmp("lit_post_rst_pc", if_pc, 32'h64);
    @(negedge clk); #1;

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
